// File: rtl/sysmon_temp_reader_pkg.sv
// sysmon_temp_reader_pkg: SYSMON temperature code conversion and reader FSM states
package sysmon_temp_reader_pkg;
  localparam real kelvin_offset = 273.15;
  localparam real code_span = 503.975;
  localparam real code_scale = 4096.0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_e;
  function automatic logic [11:0] temp_to_code(input real temp_c);
    return 12'($rtoi((temp_c + kelvin_offset) * code_scale / code_span));
  endfunction
endpackage

// File: rtl/reset_sync_n.sv
// reset_sync_n: 2-flop asynchronous-assert, synchronous-release reset synchroniser
module reset_sync_n (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_n_o = sync_q[1];
endmodule

// File: rtl/sysmon_temp_reader.sv
// sysmon_temp_reader: polls the SYSMON temperature over DRP and derives a fail-safe hysteretic alarm
module sysmon_temp_reader
  import sysmon_temp_reader_pkg::*;
#(
  parameter int         poll_cycles    = 100000,
  parameter int         timeout_cycles = 255,
  parameter logic [6:0] temp_addr      = 7'h00,
  parameter real        alarm_temp     = 85.0,
  parameter real        alarm_hyst     = 5.0
) (
  input  logic        clock,
  input  logic        async_resetn,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        sysmon_ot,
  output logic [11:0] device_temp,
  output logic        temp_valid,
  output logic        alarm,
  output logic        drp_timeout_err
);
  localparam int pw = $clog2(poll_cycles);
  localparam int tw = $clog2(timeout_cycles + 1);
  localparam logic [11:0] set_code = temp_to_code(alarm_temp);
  localparam logic [11:0] clr_code = temp_to_code(alarm_temp - alarm_hyst);
  if (poll_cycles < 8 || poll_cycles <= timeout_cycles + 3) begin : g_param_check
    $error("poll_cycles must be >= 8 and greater than timeout_cycles + 3");
  end
  logic rst_n;
  reset_sync_n u_reset_sync (.clk_i(clock), .arst_n_i(async_resetn), .rst_n_o(rst_n));
  state_e state_q, state_d;
  logic [pw-1:0] poll_q, poll_d;
  logic [tw-1:0] tmo_q, tmo_d;
  logic [11:0] sample_q, sample_d, temp_q, temp_d;
  logic valid_q, valid_d, ot_q, ot_d, err_q, err_d, alarm_q, alarm_d;
  logic unused_lsbs;
  assign unused_lsbs = ^drp_do[3:0];
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      poll_q   <= '0;
      tmo_q    <= '0;
      sample_q <= 12'hFFF;
      temp_q   <= 12'hFFF;
      valid_q  <= 1'b0;
      ot_q     <= 1'b0;
      err_q    <= 1'b0;
      alarm_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      tmo_q    <= tmo_d;
      sample_q <= sample_d;
      temp_q   <= temp_d;
      valid_q  <= valid_d;
      ot_q     <= ot_d;
      err_q    <= err_d;
      alarm_q  <= alarm_d;
    end
  // The poll counter reloads on its own so the read period ignores DRP latency
  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q == '0 ? pw'(poll_cycles - 1) : poll_q - 1'b1;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    temp_d   = temp_q;
    valid_d  = valid_q;
    ot_d     = ot_q;
    err_d    = err_q;
    alarm_d  = sysmon_ot | ot_q | !valid_q;
    case (state_q)
      IDLE: state_d = poll_q == '0 ? REQ : IDLE;
      REQ: begin
        tmo_d   = tw'(timeout_cycles);
        state_d = WAIT;
      end
      WAIT:
        if (drp_drdy) begin
          sample_d = drp_do[15:4];
          state_d  = UPDATE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end else tmo_d = tmo_q - 1'b1;
      UPDATE: begin
        temp_d  = sample_q;
        valid_d = 1'b1;
        ot_d    = sample_q >= set_code ? 1'b1 : sample_q <= clr_code ? 1'b0 : ot_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign drp_daddr       = temp_addr;
  assign drp_den         = state_q == REQ;
  assign drp_dwe         = 1'b0;
  assign drp_di          = '0;
  assign device_temp     = temp_q;
  assign temp_valid      = valid_q;
  assign alarm           = alarm_q;
  assign drp_timeout_err = err_q;
endmodule

// File: tb/tb_sysmon_temp_reader.sv
// tb_sysmon_temp_reader: randomized DRP responder checked against a behavioural reading/alarm model
module tb_sysmon_temp_reader;
  localparam int POLL = 16;
  localparam int TO = 4;
  localparam int SET_C = $rtoi((85.0 + 273.15) * 4096.0 / 503.975);
  localparam int CLR_C = $rtoi((80.0 + 273.15) * 4096.0 / 503.975);
  logic clock = 1'b0;
  logic async_resetn = 1'b0;
  logic [6:0] drp_daddr;
  logic drp_den, drp_dwe, drp_drdy, sysmon_ot;
  logic [15:0] drp_di, drp_do;
  logic [11:0] device_temp;
  logic temp_valid, alarm, drp_timeout_err;
  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_temp;
  bit exp_valid, exp_ot, exp_err;
  sysmon_temp_reader #(.poll_cycles(POLL), .timeout_cycles(TO)) dut (
    .clock(clock), .async_resetn(async_resetn), .drp_daddr(drp_daddr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .sysmon_ot(sysmon_ot), .device_temp(device_temp), .temp_valid(temp_valid),
    .alarm(alarm), .drp_timeout_err(drp_timeout_err)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  function automatic bit exp_alarm();
    return exp_ot | !exp_valid;
  endfunction
  task automatic model_reset();
    exp_temp = 12'hFFF; exp_valid = 0; exp_ot = 0; exp_err = 0;
  endtask
  task automatic apply_reset();
    async_resetn = 0; drp_drdy = 0; sysmon_ot = 0; drp_do = '0;
    repeat (2) @(negedge clock);
    async_resetn = 1;
    model_reset();
  endtask
  task automatic wait_den(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (drp_den) break;
    end
  endtask
  // d = clocks after the den cycle at which drdy is driven (1..TO+1); 0 = never answer
  task automatic do_read(input int d, input logic [15:0] data);
    int n;
    wait_den(n);
    n_checks++;
    if (drp_den !== 1'b1) begin n_fail++; $display("FAIL den_wait: no drp_den after %0d clocks", n); end
    if (d == 0) begin
      repeat (TO + 2) @(negedge clock);
      exp_valid = 0; exp_err = 1;
    end else begin
      repeat (d) @(negedge clock);
      drp_drdy = 1; drp_do = data;
      @(negedge clock);
      drp_drdy = 0; drp_do = 16'($urandom);
      @(negedge clock);
      exp_temp = data[15:4]; exp_valid = 1;
      exp_ot = (int'(exp_temp) >= SET_C) ? 1'b1 : (int'(exp_temp) <= CLR_C) ? 1'b0 : exp_ot;
    end
  endtask
  task automatic test_reset();
    int n;
    async_resetn = 0; drp_drdy = 0; sysmon_ot = 0; drp_do = '0;
    repeat (2) @(negedge clock);
    n_checks++; if (device_temp !== 12'hFFF) begin n_fail++; $display("FAIL rst_temp: got %h want fff", device_temp); end
    n_checks++; if (temp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", temp_valid); end
    n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL rst_alarm: got %b want 1", alarm); end
    n_checks++; if (drp_den !== 1'b0) begin n_fail++; $display("FAIL rst_den: got %b want 0", drp_den); end
    n_checks++; if (drp_timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", drp_timeout_err); end
    n_checks++; if (drp_daddr !== 7'h00 || drp_dwe !== 1'b0 || drp_di !== 16'h0) begin
      n_fail++; $display("FAIL rst_drp_static: daddr %h dwe %b di %h want 00 0 0000", drp_daddr, drp_dwe, drp_di); end
    async_resetn = 1;
    model_reset();
    wait_den(n);
    n_checks++; if (drp_den !== 1'b1 || n > 3) begin n_fail++; $display("FAIL rst_first_den: den %b after %0d clocks want within 3", drp_den, n); end
  endtask
  task automatic test_no_response();
    int n, k;
    apply_reset();
    wait_den(n);
    n_checks++; if (drp_den !== 1'b1 || n > 3) begin n_fail++; $display("FAIL nr_first_den: den %b after %0d clocks", drp_den, n); end
    @(negedge clock);
    n_checks++; if (drp_den !== 1'b0) begin n_fail++; $display("FAIL nr_den_pulse: got %b want 0", drp_den); end
    k = 1;
    while (k < 20 && drp_timeout_err !== 1'b1) begin @(negedge clock); k++; end
    n_checks++; if (k != TO + 2) begin n_fail++; $display("FAIL nr_err_delay: got %0d want %0d", k, TO + 2); end
    n_checks++; if (temp_valid !== 1'b0 || alarm !== 1'b1 || device_temp !== 12'hFFF) begin
      n_fail++; $display("FAIL nr_outputs: valid %b alarm %b temp %h want 0 1 fff", temp_valid, alarm, device_temp); end
    while (k < 40 && drp_den !== 1'b1) begin @(negedge clock); k++; end
    n_checks++; if (k != POLL) begin n_fail++; $display("FAIL nr_period: got %0d want %0d", k, POLL); end
    repeat (TO + 2) @(negedge clock);
    exp_err = 1;
    n_checks++; if (drp_timeout_err !== 1'b1 || temp_valid !== 1'b0) begin
      n_fail++; $display("FAIL nr_sticky: err %b valid %b want 1 0", drp_timeout_err, temp_valid); end
  endtask
  task automatic test_basic_read();
    apply_reset();
    do_read(2, 16'hA420);
    n_checks++; if (device_temp !== 12'hA42) begin n_fail++; $display("FAIL basic_temp: got %h want a42", device_temp); end
    n_checks++; if (temp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", temp_valid); end
    @(negedge clock);
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL basic_alarm: got %b want 0", alarm); end
  endtask
  task automatic test_last_cycle();
    do_read(TO + 1, {12'd2000, 4'h7});
    n_checks++; if (device_temp !== exp_temp || temp_valid !== 1'b1) begin
      n_fail++; $display("FAIL last_temp: temp %h valid %b want %h 1", device_temp, temp_valid, exp_temp); end
    n_checks++; if (drp_timeout_err !== 1'b0) begin n_fail++; $display("FAIL last_err: got %b want 0", drp_timeout_err); end
  endtask
  task automatic test_hysteresis();
    int codes[4] = '{2909, 2910, 2880, 2870};
    bit want[4] = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      do_read($urandom_range(1, TO + 1), {12'(codes[i]), 4'($urandom)});
      n_checks++; if (device_temp !== 12'(codes[i])) begin n_fail++; $display("FAIL hyst_temp[%0d]: got %0d want %0d", i, device_temp, codes[i]); end
      @(negedge clock);
      n_checks++; if (alarm !== want[i] || alarm !== exp_alarm()) begin
        n_fail++; $display("FAIL hyst_alarm[%0d]: got %b want %b", i, alarm, want[i]); end
    end
  endtask
  task automatic test_sysmon_ot();
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL ot_pre: got %b want 0", alarm); end
    sysmon_ot = 1;
    @(negedge clock);
    sysmon_ot = 0;
    n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL ot_high: got %b want 1", alarm); end
    @(negedge clock);
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL ot_low: got %b want 0", alarm); end
  endtask
  task automatic test_idle_drdy();
    do_read(1, 16'h8000);
    drp_drdy = 1; drp_do = 16'h3330;
    @(negedge clock);
    drp_drdy = 0;
    repeat (3) @(negedge clock);
    n_checks++; if (device_temp !== exp_temp || temp_valid !== 1'b1) begin
      n_fail++; $display("FAIL idle_drdy: temp %h valid %b want %h 1", device_temp, temp_valid, exp_temp); end
  endtask
  task automatic test_random();
    int d, code;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, TO + 1);
      code = $urandom_range(0, 1) ? $urandom_range(2860, 2920) : $urandom_range(0, 4095);
      do_read(d, {12'(code), 4'($urandom)});
      n_checks++; if (device_temp !== exp_temp || temp_valid !== exp_valid || drp_timeout_err !== exp_err) begin
        n_fail++; $display("FAIL rand[%0d] d=%0d: temp %h valid %b err %b want %h %b %b", i, d,
          device_temp, temp_valid, drp_timeout_err, exp_temp, exp_valid, exp_err); end
      @(negedge clock);
      n_checks++; if (alarm !== exp_alarm()) begin n_fail++; $display("FAIL rand_alarm[%0d]: got %b want %b", i, alarm, exp_alarm()); end
    end
  endtask
  task automatic test_reset_mid_read();
    int n;
    wait_den(n);
    @(negedge clock);
    async_resetn = 0;
    #1;
    n_checks++; if (drp_den !== 1'b0 || device_temp !== 12'hFFF || temp_valid !== 1'b0 || alarm !== 1'b1 || drp_timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: den %b temp %h valid %b alarm %b err %b want 0 fff 0 1 0",
        drp_den, device_temp, temp_valid, alarm, drp_timeout_err); end
    model_reset();
    @(negedge clock);
    async_resetn = 1; drp_drdy = 1; drp_do = 16'h5550;
    @(negedge clock);
    drp_drdy = 0;
    wait_den(n);
    n_checks++; if (drp_den !== 1'b1 || n + 1 > 3) begin n_fail++; $display("FAIL midrst_den: den %b after %0d clocks want within 3", drp_den, n + 1); end
    n_checks++; if (device_temp !== 12'hFFF) begin n_fail++; $display("FAIL midrst_late_drdy: got %h want fff", device_temp); end
  endtask
  initial begin
    drp_drdy = 0; sysmon_ot = 0; drp_do = '0;
    test_reset();
    test_no_response();
    test_basic_read();
    test_last_cycle();
    test_hysteresis();
    test_sysmon_ot();
    test_idle_drdy();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
